// File: rtl/pe_sched_pkg.sv
// Shared definitions for the PE scheduler: default PE geometry and the
// issue tag that travels alongside every operation through the PE.
package pe_sched_pkg;

  localparam int unsigned PRECISION_DEF       = 32;
  localparam int unsigned NUM_REQ_DEF         = 4;
  // Latencies of the PE cores this scheduler is paired with.
  localparam int unsigned MULT_LAT_DEF        = 10;
  localparam int unsigned ADD_LAT_DEF         = 25;
  localparam int unsigned MAX_OUTSTANDING_DEF = 8;

  // The index field is sized for the largest supported requester count (8),
  // so one tag type serves every legal NUM_REQ.
  localparam int unsigned TAG_IDX_W = 3;

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] index;
  } tag_t;

endpackage

// File: rtl/pe_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant to the first requesting
// index at or after the pointer; the pointer moves past the winner.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  gnt_o,
  output logic          gnt_valid_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;

  // Scan from the pointer upward, wrapping, and grant the first requester.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    sum_s       = '0;
    cand_s      = '0;
    for (int k = 0; k < int'(N); k++) begin
      sum_s = {1'b0, ptr_q} + (IW+1)'(k);
      if (sum_s >= (IW+1)'(N)) begin
        sum_s = sum_s - (IW+1)'(N);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!gnt_valid_o && req_i[cand_s]) begin
        gnt_valid_o   = 1'b1;
        gnt_idx_o     = cand_s;
        gnt_o[cand_s] = 1'b1;
      end else begin
        gnt_valid_o = gnt_valid_o;
      end
    end
  end

  // Next pointer: one past the winner, modulo N; unchanged without a grant.
  always_comb begin
    if (!gnt_valid_o) begin
      ptr_d = ptr_q;
    end else if (gnt_idx_o == IW'(N-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = gnt_idx_o + IW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/pe_scheduler.sv
// PE scheduler: shares one pipelined multiply/subtract PE among NUM_REQ
// requesters. Each issue carries a tag through a fixed-latency pipeline so
// the product and the difference are routed back to the issuing requester.
// Optional statistics counters are built when PE_SCHED_STATS_EN is defined.
module pe_scheduler
  import pe_sched_pkg::*;
#(
  parameter int unsigned PRECISION       = PRECISION_DEF,
  parameter int unsigned NUM_REQ         = NUM_REQ_DEF,
  parameter int unsigned MULT_LAT        = MULT_LAT_DEF,
  parameter int unsigned ADD_LAT         = ADD_LAT_DEF,
  parameter int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*PRECISION-1:0]   req_a,
  input  logic [NUM_REQ*PRECISION-1:0]   req_b,
  input  logic [NUM_REQ*PRECISION-1:0]   req_c,
  output logic [PRECISION-1:0]           pe_a,
  output logic [PRECISION-1:0]           pe_b,
  output logic [PRECISION-1:0]           pe_c,
  input  logic [PRECISION-1:0]           pe_mult_result,
  input  logic [PRECISION-1:0]           pe_add_result,
  output logic [NUM_REQ-1:0]             mult_valid,
  output logic [PRECISION-1:0]           mult_data,
  output logic [NUM_REQ-1:0]             add_valid,
  output logic [PRECISION-1:0]           add_data,
  output logic                           busy
`ifdef PE_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]          stat_issue_cnt,
  output logic [31:0]                    stat_stall_cnt
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  function automatic logic [NUM_REQ-1:0] tag_onehot(input tag_t t);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      oh[i] = t.valid && (t.index == TAG_IDX_W'(i));
    end
    return oh;
  endfunction

  logic [NUM_REQ-1:0]   eligible_s;
  logic [NUM_REQ-1:0]   gnt_s;
  logic                 gnt_valid_s;
  logic [IDX_W-1:0]     gnt_idx_s;
  logic [PRECISION-1:0] sel_a_s, sel_b_s, sel_c_s;
  tag_t                 new_tag_s;
  logic [NUM_REQ-1:0]   pop_s;
  logic                 busy_s;

  logic [PRECISION-1:0] pe_a_q, pe_b_q;
  logic [PRECISION-1:0] c_q [MULT_LAT+1];
  tag_t                 tag_q [ADD_LAT+1];
  logic [CNT_W-1:0]     out_q [NUM_REQ];
  logic [CNT_W-1:0]     out_d [NUM_REQ];
  logic [NUM_REQ-1:0]   mult_valid_q, mult_valid_d;
  logic [NUM_REQ-1:0]   add_valid_q, add_valid_d;
  logic [PRECISION-1:0] mult_data_q, mult_data_d;
  logic [PRECISION-1:0] add_data_q, add_data_d;

  // A requester competes only while it has headroom below its in-flight cap.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      eligible_s[i] = req_valid[i] && (out_q[i] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (eligible_s),
    .gnt_o       (gnt_s),
    .gnt_valid_o (gnt_valid_s),
    .gnt_idx_o   (gnt_idx_s)
  );

  assign req_ready = gnt_s;

  // Operand mux driven by the one-hot grant; zero when nothing is issued.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    sel_c_s = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      sel_a_s = sel_a_s | (req_a[i*PRECISION +: PRECISION] & {PRECISION{gnt_s[i]}});
      sel_b_s = sel_b_s | (req_b[i*PRECISION +: PRECISION] & {PRECISION{gnt_s[i]}});
      sel_c_s = sel_c_s | (req_c[i*PRECISION +: PRECISION] & {PRECISION{gnt_s[i]}});
    end
    new_tag_s.valid = gnt_valid_s;
    new_tag_s.index = TAG_IDX_W'(gnt_idx_s);
  end

  // Result routing: taps at the product and difference depths, and the
  // requester whose operation leaves the pipeline this cycle.
  always_comb begin
    mult_valid_d = tag_onehot(tag_q[MULT_LAT]);
    add_valid_d  = tag_onehot(tag_q[ADD_LAT]);
    pop_s        = add_valid_d;
    mult_data_d  = tag_q[MULT_LAT].valid ? pe_mult_result : '0;
    add_data_d   = tag_q[ADD_LAT].valid  ? pe_add_result  : '0;
  end

  // In-flight counters: +1 on grant, -1 as the tag leaves; both cancel.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt_s[i] && !pop_s[i]) begin
        out_d[i] = out_q[i] + CNT_W'(1);
      end else if (!gnt_s[i] && pop_s[i]) begin
        out_d[i] = out_q[i] - CNT_W'(1);
      end else begin
        out_d[i] = out_q[i];
      end
    end
  end

  // Busy while any tag, counter, or just-registered result is live.
  always_comb begin
    busy_s = (|mult_valid_q) || (|add_valid_q);
    for (int k = 0; k <= int'(ADD_LAT); k++) begin
      busy_s = busy_s || tag_q[k].valid;
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      busy_s = busy_s || (out_q[i] != '0);
    end
  end

  // Datapath and tag pipelines; C is delayed to meet the product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_a_q       <= '0;
      pe_b_q       <= '0;
      mult_valid_q <= '0;
      add_valid_q  <= '0;
      mult_data_q  <= '0;
      add_data_q   <= '0;
      for (int k = 0; k <= int'(MULT_LAT); k++) c_q[k]   <= '0;
      for (int k = 0; k <= int'(ADD_LAT); k++)  tag_q[k] <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++)   out_q[i] <= '0;
    end else begin
      pe_a_q       <= sel_a_s;
      pe_b_q       <= sel_b_s;
      mult_valid_q <= mult_valid_d;
      add_valid_q  <= add_valid_d;
      mult_data_q  <= mult_data_d;
      add_data_q   <= add_data_d;
      c_q[0]       <= sel_c_s;
      for (int k = 1; k <= int'(MULT_LAT); k++) c_q[k] <= c_q[k-1];
      tag_q[0]     <= new_tag_s;
      for (int k = 1; k <= int'(ADD_LAT); k++) tag_q[k] <= tag_q[k-1];
      for (int i = 0; i < int'(NUM_REQ); i++)  out_q[i] <= out_d[i];
    end
  end

  assign pe_a       = pe_a_q;
  assign pe_b       = pe_b_q;
  assign pe_c       = c_q[MULT_LAT];
  assign mult_valid = mult_valid_q;
  assign mult_data  = mult_data_q;
  assign add_valid  = add_valid_q;
  assign add_data   = add_data_q;
  assign busy       = busy_s;

`ifdef PE_SCHED_STATS_EN
  logic [31:0] issue_cnt_q [NUM_REQ];
  logic [31:0] stall_cnt_q;

  // Grant counters per requester and a count of contended idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) issue_cnt_q[i] <= '0;
    end else begin
      if ((|req_valid) && !gnt_valid_s) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (gnt_s[i]) begin
          issue_cnt_q[i] <= issue_cnt_q[i] + 32'd1;
        end else begin
          issue_cnt_q[i] <= issue_cnt_q[i];
        end
      end
    end
  end

  // Flatten the counters onto the statistics ports.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      stat_issue_cnt[i*32 +: 32] = issue_cnt_q[i];
    end
  end

  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pe_scheduler.sv
// Bench for pe_scheduler with a behavioural floating-point PE and a
// scoreboard of expected routed results.
module tb_pe_scheduler;

  localparam int P  = 32;
  localparam int N  = 4;
  localparam int ML = 10;
  localparam int AL = 25;
  localparam int MO = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*P-1:0] req_a, req_b, req_c;
  logic [P-1:0]   pe_a, pe_b, pe_c, pe_mult_result, pe_add_result;
  logic [N-1:0]   mult_valid, add_valid;
  logic [P-1:0]   mult_data, add_data;
  logic           busy;
`ifdef PE_SCHED_STATS_EN
  logic [N*32-1:0] stat_issue_cnt;
  logic [31:0]     stat_stall_cnt;
`endif

  pe_scheduler #(.PRECISION(P), .NUM_REQ(N), .MULT_LAT(ML), .ADD_LAT(AL),
                 .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .pe_a(pe_a), .pe_b(pe_b), .pe_c(pe_c),
    .pe_mult_result(pe_mult_result), .pe_add_result(pe_add_result),
    .mult_valid(mult_valid), .mult_data(mult_data),
    .add_valid(add_valid), .add_data(add_data), .busy(busy)
`ifdef PE_SCHED_STATS_EN
    , .stat_issue_cnt(stat_issue_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // IEEE-754 single <-> real for normal numbers and zero.
  function automatic real f2r(input logic [31:0] a);
    logic [10:0] e;
    logic [63:0] d;
    if (a[30:23] == 8'd0) return 0.0;
    e = {3'b000, a[30:23]} + 11'd896;
    d = {a[31], e, a[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural PE: product after ML cycles, C - product after AL cycles,
  // with C sampled at the subtractor input alongside the product.
  logic [31:0] pm [ML];
  logic [31:0] pd [AL-ML];
  always @(posedge clk) begin
    pm[0] <= r2f(f2r(pe_a) * f2r(pe_b));
    for (int k = 1; k < ML; k++) pm[k] <= pm[k-1];
    pd[0] <= r2f(f2r(pe_c) - f2r(pm[ML-1]));
    for (int k = 1; k < AL-ML; k++) pd[k] <= pd[k-1];
  end
  assign pe_mult_result = pm[ML-1];
  assign pe_add_result  = pd[AL-ML-1];

  // Hand-computed vectors: A, B, C, A*B, C-A*B (IEEE-754 single).
  logic [31:0] va [8] = '{32'h40000000, 32'h3F800000, 32'h3F800000, 32'h40000000,
                          32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] vb [8] = '{32'h40400000, 32'h40000000, 32'h3F800000, 32'h40000000,
                          32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] vc [8] = '{32'h41200000, 32'h3F800000, 32'h40000000, 32'h40400000,
                          32'h40400000, 32'h3F800000, 32'h40000000, 32'h40400000};
  logic [31:0] vp [8] = '{32'h40C00000, 32'h40000000, 32'h3F800000, 32'h40800000,
                          32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
  logic [31:0] vd [8] = '{32'h40800000, 32'hBF800000, 32'h3F800000, 32'hBF800000,
                          32'h00000000, 32'h00000000, 32'h3F800000, 32'h40000000};

  typedef struct { int cyc; int idx; logic [31:0] data; } exp_t;
  exp_t mq[$];
  exp_t aq[$];
  exp_t popq[$];

  int checks = 0;
  int errors = 0;
  int vec_sel [N];
  int out_m   [N];
  int ptr_m;
  int dut_gnt_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    aq.delete();
    popq.delete();
    ptr_m = 0;
    for (int i = 0; i < N; i++) out_m[i] = 0;
  endtask

  // Reference arbitration/credit model; pushes expected results per grant.
  initial begin
    exp_t e;
    int   eg, c;
    logic [N-1:0] exp_rdy;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst) begin
        while (popq.size() != 0 && popq[0].cyc <= cyc) begin
          e = popq.pop_front();
          out_m[e.idx]--;
        end
        eg = -1;
        for (int k = 0; k < N; k++) begin
          c = (ptr_m + k) % N;
          if (eg < 0 && req_valid[c] && out_m[c] < MO) eg = c;
        end
        exp_rdy = '0;
        if (eg >= 0) exp_rdy[eg] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if ((req_valid & req_ready) != '0) dut_gnt_cnt++;
        if (eg >= 0) begin
          mq.push_back('{cyc + ML + 2, eg, vp[vec_sel[eg]]});
          aq.push_back('{cyc + AL + 2, eg, vd[vec_sel[eg]]});
          popq.push_back('{cyc + AL + 2, eg, 32'd0});
          out_m[eg]++;
          ptr_m = (eg + 1) % N;
        end
      end
    end
  end

  // Result monitor: every flagged result must match the oldest expectation.
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mult_valid != '0) begin
          if (mq.size() == 0) begin
            check("mult_unexpected", 64'(mult_valid), 64'd0);
          end else begin
            e = mq.pop_front();
            oh = '0; oh[e.idx] = 1'b1;
            check("mult_cycle", 64'(cyc), 64'(e.cyc));
            check("mult_onehot", 64'(mult_valid), 64'(oh));
            check("mult_data", 64'(mult_data), 64'(e.data));
          end
        end else if (mq.size() != 0 && mq[0].cyc <= cyc) begin
          e = mq.pop_front();
          oh = '0; oh[e.idx] = 1'b1;
          check("mult_missing", 64'(mult_valid), 64'(oh));
        end
        if (add_valid != '0) begin
          if (aq.size() == 0) begin
            check("add_unexpected", 64'(add_valid), 64'd0);
          end else begin
            e = aq.pop_front();
            oh = '0; oh[e.idx] = 1'b1;
            check("add_cycle", 64'(cyc), 64'(e.cyc));
            check("add_onehot", 64'(add_valid), 64'(oh));
            check("add_data", 64'(add_data), 64'(e.data));
          end
        end else if (aq.size() != 0 && aq[0].cyc <= cyc) begin
          e = aq.pop_front();
          oh = '0; oh[e.idx] = 1'b1;
          check("add_missing", 64'(add_valid), 64'(oh));
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_req(input int i, input int v);
    req_valid[i]     = 1'b1;
    vec_sel[i]       = v;
    req_a[i*P +: P]  = va[v];
    req_b[i*P +: P]  = vb[v];
    req_c[i*P +: P]  = vc[v];
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_c = '0;
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mult_valid", 64'(mult_valid), 64'd0);
    check("rst_add_valid", 64'(add_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pe_a", 64'(pe_a), 64'd0);
    check("rst_pe_b", 64'(pe_b), 64'd0);
    check("rst_pe_c", 64'(pe_c), 64'd0);
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b1;
    model_reset();
    cycles(2);
    check_reset_state();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_reqs();
    for (int i = 0; i < N; i++) vec_sel[i] = 0;
    dut_gnt_cnt = 0;
    cycles(3);
    check_reset_state();
    rst = 1'b0;
    cycles(1);

    // Single requester 0: 2.0*3.0 = 6.0 and 10.0-6.0 = 4.0.
    set_req(0, 0);
    cycles(1);
    clear_reqs();
    cycles(35);
    check("busy_after_single", 64'(busy), 64'd0);

    // All four requesting from pointer 0: grants rotate 0,1,2,3,...
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, i + 1);
    cycles(16);
    clear_reqs();
    cycles(35);

    // Requester 1 alone: in-flight cap of 8, reopens at first add_valid.
    set_req(1, 5);
    dut_gnt_cnt = 0;
    cycles(27);
    check("cap_grants", 64'(dut_gnt_cnt), 64'd8);
    cycles(10);
    clear_reqs();
    cycles(35);

    // Back-to-back issues with C = 1.0, 2.0, 3.0.
    set_req(0, 5); cycles(1);
    set_req(0, 6); cycles(1);
    set_req(0, 7); cycles(1);
    clear_reqs();
    cycles(35);

    // Reset mid-flight: nothing from these issues may ever be flagged.
    set_req(3, 0);
    cycles(3);
    clear_reqs();
    cycles(5);
    do_reset();
    cycles(40);
    check("busy_after_abort", 64'(busy), 64'd0);
    for (int i = 0; i < N; i++) set_req(i, 0);
    cycles(1);
    clear_reqs();
    cycles(35);

    // Grants and contended idle cycles for the statistics counters.
    do_reset();
    set_req(2, 2); cycles(5); clear_reqs(); cycles(30);
    set_req(2, 2); cycles(5); clear_reqs(); cycles(30);
    set_req(1, 1); cycles(11); clear_reqs(); cycles(35);
`ifdef PE_SCHED_STATS_EN
    check("stat_issue_cnt2", 64'(stat_issue_cnt[2*32 +: 32]), 64'd10);
    check("stat_stall_cnt", 64'(stat_stall_cnt), 64'd3);
`endif

    check("busy_final", 64'(busy), 64'd0);
    check("queues_drained", 64'(mq.size() + aq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_scheduler.md
Name: pe_scheduler

Overview:
- Time-multiplexes one fully pipelined PE (multiply A*B, then C-(A*B)) between NUM_REQ requesters.
- Round-robin arbitration issues at most one operation per cycle.
- Holds each operation's C operand for MULT_LAT cycles so it meets the product at the subtractor input.
- Tags every issue so both results are routed back to the originating requester; sits between the NoC router ports and a PE instance.

Parameters:
PRECISION, 32, operand/result width in bits
NUM_REQ, 4, number of requesters (2..8)
MULT_LAT, 10, cycles from PE A/B input to mult_result
ADD_LAT, 25, cycles from PE A/B input to add_result (must exceed MULT_LAT)
MAX_OUTSTANDING, 8, per-requester in-flight limit (1..ADD_LAT)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester operation request
req_ready  output  NUM_REQ  one-hot grant; the operation transfers when req_valid[i]&req_ready[i]
req_a  input  NUM_REQ*PRECISION  A operands, requester i at slice i
req_b  input  NUM_REQ*PRECISION  B operands
req_c  input  NUM_REQ*PRECISION  C operands
pe_a  output  PRECISION  to PE A
pe_b  output  PRECISION  to PE B
pe_c  output  PRECISION  to PE C, delayed copy
pe_mult_result  input  PRECISION  from PE
pe_add_result  input  PRECISION  from PE
mult_valid  output  NUM_REQ  one-hot, product for requester i on mult_data
mult_data  output  PRECISION  routed product
add_valid  output  NUM_REQ  one-hot, C-(A*B) for requester i on add_data
add_data  output  PRECISION  routed difference
busy  output  1  any operation in flight

Behaviour:
- Reset (async assert, sync release): req_ready=0, mult_valid=0, add_valid=0, busy=0, pe_a/pe_b/pe_c=0, all outstanding counters=0, round-robin pointer=0, tag pipeline cleared.
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i]<MAX_OUTSTANDING.
- Arbitration is combinational. req_ready is one-hot, granting the first eligible index at or after the pointer, wrapping modulo NUM_REQ.
- On a grant to requester g, the pointer becomes (g+1) mod NUM_REQ at the clock edge. With no grant, the pointer holds.
- Issue at cycle t: pe_a/pe_b are registered from slice g, so they are valid at t+1. Cycles in which nothing is issued drive zero.
- C path: req_c[g] enters a MULT_LAT-deep shift register aligned so pe_c carries it exactly when the PE's product reaches its subtractor input register (PE-input cycle + MULT_LAT).
- Tag pipeline: a {valid, index} entry is pushed every cycle (valid=0 when idle) into an ADD_LAT-deep shift register.
- The tap at depth MULT_LAT drives mult_valid=onehot(index), and mult_data is registered pe_mult_result. The tap at depth ADD_LAT does the same for add_valid/add_data.
- Results are aligned so both appear in the same cycle their tag pops.
- End-to-end latency from the grant cycle: mult_valid at t+MULT_LAT+2, add_valid at t+ADD_LAT+2. Both are fixed, with no jitter.
- Responses have no backpressure; requesters must accept them.
- outstanding[i]: +1 on grant to i, −1 when add_valid[i] pops. A simultaneous grant and pop leaves it unchanged. It never exceeds MAX_OUTSTANDING and never underflows.
- busy=1 while any tag valid bit or any outstanding counter is nonzero.
- When all requesters are ineligible, there is no grant and the pipelines keep draining.
- rst asserted mid-operation discards all in-flight tags. No results for those operations are ever flagged.

Optional Feature:
- Macro: PE_SCHED_STATS_EN.
- When defined: adds output stat_issue_cnt (NUM_REQ*32), per-requester grant counters that wrap at 2^32 and reset to 0, and output stat_stall_cnt (32), which increments in each cycle where some req_valid=1 but no grant is made.
- When undefined: these ports and counters are absent and there is no other change.

Decomposition:
- Shared package pe_sched_pkg: PRECISION default, MULT_LAT/ADD_LAT constants matching the PE cores, tag typedef {valid, index[$clog2(NUM_REQ)-1:0]}.
- One natural sub-module: rr_arbiter (NUM_REQ-wide request/grant with pointer), reusable by the NoC routers.

Test Plan:
- Single requester 0, A=2.0, B=3.0, C=10.0 (IEEE-754) at cycle t -> mult_valid=0001 with 6.0 at t+12; add_valid=0001 with 4.0 at t+27.
- All 4 requesters valid continuously from pointer 0 -> grants rotate 0,1,2,3,0…; each result pops with the matching one-hot, in issue order.
- Requester 1 valid continuously, MAX_OUTSTANDING=8 -> exactly 8 grants, then req_ready[1]=0 until first add_valid[1]; grant and pop in the same cycle keep the count at 8.
- Back-to-back issues with distinct C values (1.0,2.0,3.0) -> each add_data equals its own C−A*B, confirming C delay alignment.
- rst pulsed 5 cycles after 3 issues -> no mult_valid/add_valid ever asserted for them; busy=0; pointer=0.
- With PE_SCHED_STATS_EN, 10 grants to requester 2 plus 3 contended idle cycles -> stat_issue_cnt[2]=10, stat_stall_cnt=3.
